// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-CPU memory bus arbiter with snoop-based coherence hooks. One RAM
//   transaction is in flight at a time. Data requests beat instruction
//   requests. CPU ties go to whichever CPU was not granted last.
//
//   Configuration macro: BUS_FIXED_PRIO_EN
//     When defined, CPU0 always wins ties and last-granted is ignored.
//     When undefined, ties alternate.
//
//   Ports (CPUS = 2, WORD_W = word width)
//     CLK, nRST                      clock, async active-low reset
//     iREN/iaddr -> iload/iwait      instruction-fetch side, per CPU
//     dREN/dWEN/daddr/dstore         data-cache side, per CPU
//       -> dload/dwait               (dREN & dWEN together is a write)
//     cctrans/ccwrite                coherence request qualifiers, per CPU
//       -> ccwait/ccinv/ccsnoopaddr  snoop controls toward the other CPU
//     ramREN/ramWEN/ramaddr/ramstore RAM request
//     ramload, ramwait               RAM response (ramwait = 1: not ready)
//
//   Only CPUS = 2 is supported. The grant is a single bit and "other"
//   is its complement.
module mem_bus_arbiter #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction-fetch side
  input  logic [CPUS-1:0]   iREN,
  input  logic [WORD_W-1:0] iaddr [CPUS],
  output logic [WORD_W-1:0] iload [CPUS],
  output logic [CPUS-1:0]   iwait,
  // data-cache side
  input  logic [CPUS-1:0]   dREN,
  input  logic [CPUS-1:0]   dWEN,
  input  logic [WORD_W-1:0] daddr [CPUS],
  input  logic [WORD_W-1:0] dstore [CPUS],
  output logic [WORD_W-1:0] dload [CPUS],
  output logic [CPUS-1:0]   dwait,
  // coherence side
  input  logic [CPUS-1:0]   cctrans,
  input  logic [CPUS-1:0]   ccwrite,
  output logic [CPUS-1:0]   ccwait,
  output logic [CPUS-1:0]   ccinv,
  output logic [WORD_W-1:0] ccsnoopaddr [CPUS],
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramwait
);

  // The encoding values are kept from the legacy localparams.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    D_RD  = 3'd2,
    D_WR  = 3'd3,
    I_RD  = 3'd4
  } state_t;

  state_t state, state_n;
  logic   grant, grant_n;     // CPU owning the current transaction
  logic   last, last_n;       // CPU whose access completed most recently
  logic   snooped, snooped_n; // current D_RD was preceded by a SNOOP cycle
  logic   other;
  logic   tie_pref;           // winner when both CPUs request
  logic   pick;
  logic [CPUS-1:0] dreq;

`ifdef BUS_FIXED_PRIO_EN
  assign tie_pref = 1'b0;
`else
  assign tie_pref = ~last;
`endif

  assign other = ~grant;
  assign dreq  = dREN | dWEN;

  function automatic logic pick_cpu(input logic [1:0] req, input logic pref);
    if (req == 2'b11) return pref;
    else              return req[1];
  endfunction

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    last_n      = last;
    snooped_n   = snooped;
    pick        = 1'b0;
    iwait       = '1;
    dwait       = '1;
    iload       = '{default: '0};
    dload       = '{default: '0};
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '{default: '0};
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state)
      IDLE: begin
        snooped_n = 1'b0;
        if (|dreq) begin
          pick    = pick_cpu(dreq, tie_pref);
          grant_n = pick;
          if (dWEN[pick]) begin
            state_n = D_WR;
          end else if (cctrans[pick]) begin
            state_n   = SNOOP;
            snooped_n = 1'b1;
          end else begin
            state_n = D_RD;
          end
        end else if (|iREN) begin
          pick    = pick_cpu(iREN, tie_pref);
          grant_n = pick;
          state_n = I_RD;
        end
      end

      SNOOP: begin
        if (!dREN[grant]) begin
          state_n = IDLE;
        end else begin
          ccwait[other]      = 1'b1;
          ccinv[other]       = ccwrite[grant];
          ccsnoopaddr[other] = daddr[grant];
          state_n            = D_RD;
        end
      end

      // A dropped request aborts without touching RAM or pulsing a wait.
      D_RD: begin
        if (!dREN[grant]) begin
          state_n = IDLE;
        end else begin
          ccwait[other] = snooped;
          ramREN        = 1'b1;
          ramaddr       = daddr[grant];
          if (!ramwait) begin
            dwait[grant] = 1'b0;
            dload[grant] = ramload;
            last_n       = grant;
            state_n      = IDLE;
          end
        end
      end

      D_WR: begin
        if (!dWEN[grant]) begin
          state_n = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[grant];
          ramstore = dstore[grant];
          if (!ramwait) begin
            dwait[grant] = 1'b0;
            last_n       = grant;
            state_n      = IDLE;
          end
        end
      end

      I_RD: begin
        if (!iREN[grant]) begin
          state_n = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[grant];
          if (!ramwait) begin
            iwait[grant] = 1'b0;
            iload[grant] = ramload;
            last_n       = grant;
            state_n      = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Resetting last to CPU1 lets CPU0 win the first tie.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      grant   <= 1'b0;
      last    <= 1'b1;
      snooped <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      last    <= last_n;
      snooped <= snooped_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter.
// Scoreboard: request tasks push the expected completion per port. A
// negedge monitor pops one entry on each wait-low pulse and compares the
// RAM request, the returned load, and the snoop activity seen beforehand.
module tb_mem_bus_arbiter;
  localparam int W     = 32;
  localparam int BOUND = 500;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic         iren_s [2];
  logic         dren_s [2];
  logic         dwen_s [2];
  logic         cct_s  [2];
  logic         ccw_s  [2];
  logic [W-1:0] iaddr_s  [2];
  logic [W-1:0] daddr_s  [2];
  logic [W-1:0] dstore_s [2];
  logic [W-1:0] iload [2];
  logic [W-1:0] dload [2];
  logic [W-1:0] snp   [2];
  logic [1:0]   iwait, dwait, ccwait, ccinv;
  logic         ramREN, ramWEN, ramwait;
  logic [W-1:0] ramaddr, ramstore, ramload;

  mem_bus_arbiter #(.CPUS(2), .WORD_W(W)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .iREN       ({iren_s[1], iren_s[0]}),
    .iaddr      (iaddr_s),
    .iload      (iload),
    .iwait      (iwait),
    .dREN       ({dren_s[1], dren_s[0]}),
    .dWEN       ({dwen_s[1], dwen_s[0]}),
    .daddr      (daddr_s),
    .dstore     (dstore_s),
    .dload      (dload),
    .dwait      (dwait),
    .cctrans    ({cct_s[1], cct_s[0]}),
    .ccwrite    ({ccw_s[1], ccw_s[0]}),
    .ccwait     (ccwait),
    .ccinv      (ccinv),
    .ccsnoopaddr(snp),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ramwait    (ramwait)
  );

  // RAM contents model: a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction
  assign ramload = mem_f(ramaddr);

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          snoop;
    bit          inv;
  } exp_t;

  // port id: 0 = d0, 1 = i0, 2 = d1, 3 = i1
  exp_t q_d0[$], q_d1[$], q_i0[$], q_i1[$];
  int   order_q[$];

  int checks = 0;
  int errors = 0;
  int comp_cnt = 0;
  int snoop_cnt [2];
  logic [31:0] snoop_addr [2];
  logic        snoop_inv  [2];
  int  stall = 0;
  bit  rw_hold = 1'b0;
  bit  rw_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic check_comp(input int id, input bit have, input exp_t e);
    int c;
    int o;
    bit is_i;
    logic [1:0] cw_req;
    c    = id / 2;
    o    = 1 - c;
    is_i = (id % 2) == 1;
    comp_cnt++;
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_completion: port %0d wait low, got 0 outstanding required 1", id);
      return;
    end
    if (order_q.size() > 0) chk("grant_order", id, order_q.pop_front());
    chk("ramwait_at_completion", 32'(ramwait), 32'(0));
    chk("ramREN", 32'(ramREN), 32'(!e.wr));
    chk("ramWEN", 32'(ramWEN), 32'(e.wr));
    chk("ramaddr", ramaddr, e.addr);
    if (e.wr)      chk("ramstore", ramstore, e.data);
    else if (is_i) chk("iload", iload[c], mem_f(e.addr));
    else           chk("dload", dload[c], mem_f(e.addr));
    cw_req = !e.snoop ? 2'b00 : (o == 1 ? 2'b10 : 2'b01);
    chk("ccwait_at_completion", 32'(ccwait), 32'(cw_req));
    if (!is_i) begin
      chk("snoop_cycles", snoop_cnt[c], e.snoop ? 1 : 0);
      if (e.snoop) begin
        chk("ccsnoopaddr", snoop_addr[c], e.addr);
        chk("ccinv", 32'(snoop_inv[c]), 32'(e.inv));
      end
      snoop_cnt[c] = 0;
    end
  endtask

  // Monitor: snoop cycles are those with ccwait up but no RAM request.
  initial begin
    exp_t e;
    bit have;
    snoop_cnt[0] = 0;
    snoop_cnt[1] = 0;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        for (int o = 0; o < 2; o++) begin
          if (ccwait[o] && !ramREN && !ramWEN) begin
            snoop_cnt[1-o]++;
            snoop_addr[1-o] = snp[o];
            snoop_inv[1-o]  = ccinv[o];
          end
        end
        if (ccinv != 2'b00) chk("ccinv_outside_snoop", 32'(ramREN | ramWEN), 32'(0));
        if (dwait[0] == 1'b0) begin
          have = q_d0.size() > 0; if (have) e = q_d0.pop_front(); check_comp(0, have, e);
        end
        if (iwait[0] == 1'b0) begin
          have = q_i0.size() > 0; if (have) e = q_i0.pop_front(); check_comp(1, have, e);
        end
        if (dwait[1] == 1'b0) begin
          have = q_d1.size() > 0; if (have) e = q_d1.pop_front(); check_comp(2, have, e);
        end
        if (iwait[1] == 1'b0) begin
          have = q_i1.size() > 0; if (have) e = q_i1.pop_front(); check_comp(3, have, e);
        end
      end
    end
  end

  // RAM ready model.
  initial begin
    ramwait = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (rw_hold)      ramwait = 1'b1;
      else if (rw_rand) ramwait = ($urandom_range(0, 1) == 1);
      else if ((ramREN || ramWEN) && stall > 0) begin
        ramwait = 1'b1;
        stall--;
      end else ramwait = 1'b0;
    end
  end

  // Callers start at posedge+1; these tasks return at posedge+1.
  task automatic d_req(input int c, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit cct, input bit ccw);
    exp_t e;
    bit done;
    done    = 1'b0;
    e.wr    = wr;
    e.addr  = a;
    e.data  = d;
    e.snoop = !wr && cct;
    e.inv   = ccw;
    if (c == 0) q_d0.push_back(e); else q_d1.push_back(e);
    dren_s[c] = rd; dwen_s[c] = wr; daddr_s[c] = a; dstore_s[c] = d;
    cct_s[c] = cct; ccw_s[c] = ccw;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge CLK);
      if (dwait[c] === 1'b0) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL d_timeout: cpu %0d dwait got %b required 0 within %0d cycles", c, dwait[c], BOUND);
    end
    @(posedge CLK);
    #1;
    dren_s[c] = 1'b0; dwen_s[c] = 1'b0; cct_s[c] = 1'b0; ccw_s[c] = 1'b0;
  endtask

  task automatic i_req(input int c, input logic [31:0] a);
    exp_t e;
    bit done;
    done    = 1'b0;
    e.wr    = 1'b0;
    e.addr  = a;
    e.data  = '0;
    e.snoop = 1'b0;
    e.inv   = 1'b0;
    if (c == 0) q_i0.push_back(e); else q_i1.push_back(e);
    iren_s[c]  = 1'b1;
    iaddr_s[c] = a;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge CLK);
      if (iwait[c] === 1'b0) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL i_timeout: cpu %0d iwait got %b required 0 within %0d cycles", c, iwait[c], BOUND);
    end
    @(posedge CLK);
    #1;
    iren_s[c] = 1'b0;
  endtask

  task automatic d_agent(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      int kind;
      logic [31:0] a;
      gap  = int'($urandom_range(1, 4));
      kind = int'($urandom_range(0, 3));
      a    = $urandom & 32'hFFFF_FFFC;
      repeat (gap) @(posedge CLK);
      #1;
      d_req(c, kind != 1, kind == 1 || kind == 2, a, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic i_agent(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = int'($urandom_range(1, 3));
      repeat (gap) @(posedge CLK);
      #1;
      i_req(c, $urandom & 32'hFFFF_FFFC);
    end
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_iwait"}, 32'(iwait), 32'(2'b11));
    chk({tag, "_dwait"}, 32'(dwait), 32'(2'b11));
    chk({tag, "_ramREN"}, 32'(ramREN), 32'(0));
    chk({tag, "_ramWEN"}, 32'(ramWEN), 32'(0));
    chk({tag, "_ccwait"}, 32'(ccwait), 32'(0));
    chk({tag, "_ccinv"}, 32'(ccinv), 32'(0));
    chk({tag, "_ramaddr"}, ramaddr, 32'(0));
    chk({tag, "_ramstore"}, ramstore, 32'(0));
  endtask

  initial begin
    int snap;
    bit seen;
    for (int c = 0; c < 2; c++) begin
      iren_s[c] = 1'b0; dren_s[c] = 1'b0; dwen_s[c] = 1'b0;
      cct_s[c] = 1'b0; ccw_s[c] = 1'b0;
      iaddr_s[c] = '0; daddr_s[c] = '0; dstore_s[c] = '0;
    end
    nRST = 1'b0;
    #3;
    reset_outputs_check("rst");
    chk("rst_dload0", dload[0], 32'(0));
    chk("rst_dload1", dload[1], 32'(0));
    chk("rst_iload0", iload[0], 32'(0));
    chk("rst_iload1", iload[1], 32'(0));
    chk("rst_snoopaddr0", snp[0], 32'(0));
    chk("rst_snoopaddr1", snp[1], 32'(0));
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Snooped read on CPU0, RAM ready after two stall cycles.
    stall = 2;
    d_req(0, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b1, 1'b0);
    // Snooped read with ccwrite: invalidate the other CPU.
    stall = 1;
    d_req(0, 1'b1, 1'b0, 32'h0000_0080, '0, 1'b1, 1'b1);

    // Fresh reset, then simultaneous writes.
    nRST = 1'b0;
    #10;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    for (int r = 0; r < 2; r++) begin
      order_q.push_back(0);
      order_q.push_back(2);
      stall = 1;
      fork
        d_req(0, 1'b0, 1'b1, 32'h0000_1000 + 32'(r * 16), 32'hAAAA_0000 + 32'(r), 1'b0, 1'b0);
        d_req(1, 1'b0, 1'b1, 32'h0000_2000 + 32'(r * 16), 32'hBBBB_0000 + 32'(r), 1'b0, 1'b0);
      join
    end
    // CPU0 served alone, so a following tie favours CPU1 unless fixed priority.
    d_req(0, 1'b1, 1'b1, 32'h0000_3000, 32'hCCCC_0001, 1'b0, 1'b0);
`ifdef BUS_FIXED_PRIO_EN
    order_q.push_back(0);
    order_q.push_back(2);
`else
    order_q.push_back(2);
    order_q.push_back(0);
`endif
    fork
      d_req(0, 1'b0, 1'b1, 32'h0000_3100, 32'hCCCC_0002, 1'b0, 1'b0);
      d_req(1, 1'b0, 1'b1, 32'h0000_3200, 32'hDDDD_0002, 1'b0, 1'b0);
    join

    // CPU1 data and instruction together: data first.
    order_q.push_back(2);
    order_q.push_back(3);
    stall = 1;
    fork
      d_req(1, 1'b1, 1'b0, 32'h0000_4000, '0, 1'b0, 1'b0);
      i_req(1, 32'h0000_5000);
    join

    // Reset while a read is stalled.
    rw_hold = 1'b1;
    snap = comp_cnt;
    dren_s[0] = 1'b1;
    daddr_s[0] = 32'h0000_0100;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (ramREN) begin seen = 1'b1; break; end
    end
    chk("rd_before_reset", 32'(seen), 32'(1));
    #1;
    nRST = 1'b0;
    #1;
    reset_outputs_check("midrst");
    @(posedge CLK);
    #1;
    dren_s[0] = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    rw_hold = 1'b0;
    @(posedge CLK);
    #1;
    chk("midrst_no_completion", comp_cnt, snap);
    chk("midrst_idle_ramREN", 32'(ramREN), 32'(0));

    // Read request withdrawn while RAM is stalled.
    rw_hold = 1'b1;
    snap = comp_cnt;
    dren_s[0] = 1'b1;
    daddr_s[0] = 32'h0000_0200;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (ramREN) begin seen = 1'b1; break; end
    end
    chk("rd_before_abort", 32'(seen), 32'(1));
    @(posedge CLK);
    #1;
    dren_s[0] = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_ramREN", 32'(ramREN), 32'(0));
    chk("abort_dwait", 32'(dwait), 32'(2'b11));
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_no_completion", comp_cnt, snap);
    rw_hold = 1'b0;
    stall = 1;
    d_req(0, 1'b1, 1'b0, 32'h0000_0300, '0, 1'b0, 1'b0);

    // Randomized traffic on all four ports.
    rw_rand = 1'b1;
    fork
      d_agent(0, 25);
      d_agent(1, 25);
      i_agent(0, 15);
      i_agent(1, 15);
    join
    rw_rand = 1'b0;

    repeat (5) @(posedge CLK);
    #1;
    chk("outstanding_left", q_d0.size() + q_d1.size() + q_i0.size() + q_i1.size(), 0);
    chk("order_left", order_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of CPU ports; only the value 2 is supported.
REQ-002 SHALL have parameter WORD_W, default 32, width of address and data words.
REQ-003 SHALL have port CLK  in  1  clock.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports iREN[CPUS]  in  1, iaddr[CPUS]  in  WORD_W, iload[CPUS]  out  WORD_W, iwait[CPUS]  out  1  (instruction-fetch side).
REQ-006 SHALL have ports dREN[CPUS], dWEN[CPUS]  in  1, daddr[CPUS], dstore[CPUS]  in  WORD_W, dload[CPUS]  out  WORD_W, dwait[CPUS]  out  1  (data-cache side).
REQ-007 SHALL have ports cctrans[CPUS], ccwrite[CPUS]  in  1, ccwait[CPUS], ccinv[CPUS]  out  1, ccsnoopaddr[CPUS]  out  WORD_W  (coherence side).
REQ-008 SHALL have ports ramREN, ramWEN  out  1, ramaddr, ramstore  out  WORD_W, ramload  in  WORD_W, ramwait  in  1 (1 = RAM not ready).

Function
REQ-009 SHALL implement states IDLE, SNOOP, D_RD, D_WR, I_RD; one transaction in flight at a time.
REQ-010 SHALL in IDLE grant data requests (dREN|dWEN) over instruction requests; between CPUs, the requester not granted last wins when both request.
REQ-011 SHALL move IDLE->D_WR on a granted dWEN (write-back, no snoop); IDLE->SNOOP on a granted dREN with cctrans; IDLE->D_RD on a granted dREN without cctrans; IDLE->I_RD on a granted iREN.
REQ-012 SHALL in SNOOP (exactly 1 cycle) drive ccsnoopaddr[other]=daddr[grant] and ccinv[other]=ccwrite[grant], then go to D_RD.
REQ-013 SHALL hold ccwait[other]=1 from SNOOP entry until the D_RD access completes.
REQ-014 SHALL in D_RD/D_WR/I_RD drive ramREN/ramWEN, ramaddr and ramstore from the granted port, steady while ramwait=1.
REQ-015 SHALL on a cycle with ramwait=0 complete the access: drop the granted wait (dwait/iwait) for exactly that cycle, drive dload/iload=ramload on reads, return to IDLE, and record the granted CPU as last-granted.
REQ-016 SHALL hold every dwait/iwait at 1 except on the completion cycle of REQ-015.
REQ-017 SHALL, if the granted request drops before completion, abort to IDLE next cycle without pulsing a wait low.
REQ-018 SHALL treat dREN&dWEN together on a port as a write.
REQ-019 SHALL, when no request is pending, hold ramREN=ramWEN=0 and all ccwait/ccinv=0.

Reset
REQ-020 SHALL on nRST=0 asynchronously enter IDLE, set last-granted to CPU1 (so CPU0 wins the first tie), and clear all registers.
REQ-021 SHALL during reset drive iwait=dwait=1, ramREN=ramWEN=0, ccwait=ccinv=0, and all address/data outputs to 0.
REQ-022 SHALL, when reset is asserted mid-transaction, drop the RAM request immediately and complete no access.

Configuration
REQ-023 SHALL support macro BUS_FIXED_PRIO_EN: when defined, CPU0 always wins data and instruction ties (last-granted ignored); when undefined, REQ-010 alternation applies.

Verification
REQ-024 SHALL cover: CPU0 dREN, cctrans=1, daddr=0x0000_0040, ramwait=0 after 2 cycles -> one SNOOP cycle with ccsnoopaddr[1]=0x40, ccwait[1]=1 throughout, dwait[0] low exactly one cycle, dload[0]=ramload.
REQ-025 SHALL cover: both CPUs assert dWEN simultaneously after reset -> CPU0 served first, then CPU1; repeated tie -> CPU0 then CPU1 again (only CPU0-first when BUS_FIXED_PRIO_EN defined).
REQ-026 SHALL cover: CPU1 iREN and dREN the same cycle -> data first, iwait[1] stays 1 until the following I_RD completes.
REQ-027 SHALL cover: CPU0 dREN with ccwrite=1 -> ccinv[1]=1 during SNOOP only.
REQ-028 SHALL cover: nRST low while in D_RD with ramwait=1 -> ramREN=0 at once, state IDLE, no wait pulse.
REQ-029 SHALL cover: CPU0 dREN dropped while ramwait=1 -> return to IDLE, dwait[0] never low.
